// File: rtl/stream_cpu_core.sv
// stream_cpu_core: streamed-instruction CPU on a valid/ready bus with register file,
// scratch RAM, two-cycle registered load and selectable debug output.
module stream_cpu_core #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2,
  parameter int MEM_AW = 3,
  parameter int PC_W = 8,
  localparam int NUM_REGS = 2 ** REG_AW,
  localparam int INSTR_W = 3 + 2 * REG_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instrValid,
  output logic               instrReady,
  output logic [DATA_W-1:0]  dOut,
  output logic               carryOut,
  output logic [PC_W-1:0]    pcOut
);
  typedef enum logic {EXEC, LOAD_WAIT} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] r_q [NUM_REGS];
  logic [DATA_W-1:0] mem_q [2**MEM_AW];
  logic [DATA_W-1:0] rdata_q, a, b, wr_data;
  logic [DATA_W:0] sum, diff;
  logic [PC_W-1:0] pc_q, pc_d;
  logic carry_q, carry_d, sel_q, sel_d, rdy_q, acc, wr_en, st_en, ld_en;
  logic [REG_AW-1:0] rd, rs, ld_rd_q, wr_rd;
  logic [2:0] op;
  assign {op, rd, rs} = instr;
  assign a = r_q[rd];
  assign b = r_q[rs];
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign instrReady = rdy_q && state_q == EXEC;
  assign acc = instrValid && instrReady;
  assign dOut = sel_q ? DATA_W'(pc_q) : r_q[NUM_REGS-1];
  assign carryOut = carry_q;
  assign pcOut = pc_q;
  // the load writeback owns the register write port during LOAD_WAIT
  assign wr_rd = state_q == LOAD_WAIT ? ld_rd_q : rd;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    carry_d = carry_q;
    sel_d = sel_q;
    wr_en = state_q == LOAD_WAIT;
    wr_data = rdata_q;
    st_en = 1'b0;
    ld_en = 1'b0;
    if (state_q == LOAD_WAIT) state_d = EXEC;
    else if (acc) begin
      pc_d = pc_q + PC_W'(1);
      case (op)
        3'd0: begin wr_en = 1'b1; wr_data = sum[DATA_W-1:0]; carry_d = sum[DATA_W]; end
        3'd1: begin wr_en = 1'b1; wr_data = diff[DATA_W-1:0]; carry_d = diff[DATA_W]; end
        3'd2: begin wr_en = 1'b1; wr_data = a & b; end
        3'd3: begin wr_en = 1'b1; wr_data = a ^ b; end
        3'd4: begin wr_en = 1'b1; wr_data = b; end
        3'd5: st_en = 1'b1;
        3'd6: begin ld_en = 1'b1; state_d = LOAD_WAIT; end
        default:
          case (rd[1:0])
            2'd0: if (carry_q) begin pc_d = pc_q + PC_W'(b); carry_d = 1'b0; end
            2'd1: sel_d = !sel_q;
            2'd2: carry_d = 1'b0;
            default: ;
          endcase
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EXEC;
      pc_q <= '0;
      carry_q <= 1'b0;
      sel_q <= 1'b0;
      rdy_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_q[i] <= DATA_W'(i);
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      carry_q <= carry_d;
      sel_q <= sel_d;
      rdy_q <= 1'b1;
      if (wr_en) r_q[wr_rd] <= wr_data;
    end
  end
  // scratch RAM and load pipeline carry no reset
  always_ff @(posedge clk) begin
    if (st_en) mem_q[a[MEM_AW-1:0]] <= b;
    if (ld_en) begin
      rdata_q <= mem_q[b[MEM_AW-1:0]];
      ld_rd_q <= rd;
    end
  end
endmodule

// File: tb/tb_stream_cpu_core.sv
// tb_stream_cpu_core: directed vectors on a default and a wide instance, checked by
// per-instance scoreboards popped on every accepted instruction.
module tb_stream_cpu_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [6:0] instr0 = '0;
  logic v0 = 1'b0, r0, c0;
  logic [7:0] d0, pc0;
  logic [8:0] instr1 = '0;
  logic v1 = 1'b0, r1, c1;
  logic [15:0] d1;
  logic [3:0] pc1;
  stream_cpu_core u0 (
    .clk(clk), .rst(rst), .instr(instr0), .instrValid(v0), .instrReady(r0),
    .dOut(d0), .carryOut(c0), .pcOut(pc0)
  );
  stream_cpu_core #(.DATA_W(16), .REG_AW(3), .MEM_AW(4), .PC_W(4)) u1 (
    .clk(clk), .rst(rst), .instr(instr1), .instrValid(v1), .instrReady(r1),
    .dOut(d1), .carryOut(c1), .pcOut(pc1)
  );
  typedef struct {int id; logic [15:0] d; logic [7:0] pc; logic c; logic rdy;} exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int checks = 0, errors = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;
  always @(posedge clk) begin
    acc0 <= v0 && r0;
    acc1 <= v1 && r1;
  end
  task automatic chk(input string nm, input int id, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (acc0) begin
      if (q0.size() == 0) begin checks++; errors++; $display("FAIL u0 spurious accept"); end
      else begin
        e0 = q0.pop_front();
        chk("u0 pc", e0.id, 16'(pc0), 16'(e0.pc));
        chk("u0 carry", e0.id, 16'(c0), 16'(e0.c));
        chk("u0 dOut", e0.id, 16'(d0), e0.d);
        chk("u0 ready", e0.id, 16'(r0), 16'(e0.rdy));
      end
    end
    if (acc1) begin
      if (q1.size() == 0) begin checks++; errors++; $display("FAIL u1 spurious accept"); end
      else begin
        e1 = q1.pop_front();
        chk("u1 pc", e1.id, 16'(pc1), 16'(e1.pc));
        chk("u1 carry", e1.id, 16'(c1), 16'(e1.c));
        chk("u1 dOut", e1.id, d1, e1.d);
        chk("u1 ready", e1.id, 16'(r1), 16'(e1.rdy));
      end
    end
  end
  function automatic logic [8:0] i0(input int op, input int rd, input int rs);
    return {2'b00, op[2:0], rd[1:0], rs[1:0]};
  endfunction
  function automatic logic [8:0] i1(input int op, input int rd, input int rs);
    return {op[2:0], rd[2:0], rs[2:0]};
  endfunction
  task automatic issue(input int u, input logic [8:0] ins, input int wexp, input int id,
                       input logic [15:0] d, input logic [7:0] pc, input logic c, input logic rdy);
    exp_t e;
    int n;
    bit got;
    e = '{id, d, pc, c, rdy};
    if (u == 0) begin q0.push_back(e); instr0 = ins[6:0]; v0 = 1'b1; end
    else begin q1.push_back(e); instr1 = ins; v1 = 1'b1; end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      got = (u == 0) ? acc0 : acc1;
    end
    checks++;
    if (!got || n != wexp) begin
      errors++;
      $display("FAIL accept wait u%0d #%0d: cycles %0d expected %0d", u, id, n, wexp);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst pc0", 0, 16'(pc0), 16'h0);
    chk("rst carry0", 0, 16'(c0), 16'h0);
    chk("rst dOut0", 0, 16'(d0), 16'h3);
    chk("rst ready0", 0, 16'(r0), 16'h0);
    chk("rst dOut1", 0, d1, 16'h7);
    chk("rst ready1", 0, 16'(r1), 16'h0);
    rst = 1'b1;
    #1 chk("release ready0 pre-edge", 0, 16'(r0), 16'h0);
    @(negedge clk);
    chk("release ready0", 0, 16'(r0), 16'h1);
    chk("release ready1", 0, 16'(r1), 16'h1);
    issue(0, i0(1, 0, 1), 1, 1, 16'h03, 8'h01, 1, 1);
    issue(0, i0(7, 0, 3), 1, 2, 16'h03, 8'h04, 0, 1);
    issue(0, i0(7, 0, 3), 1, 3, 16'h03, 8'h05, 0, 1);
    issue(0, i0(5, 2, 0), 1, 4, 16'h03, 8'h06, 0, 1);
    issue(0, i0(6, 1, 2), 1, 5, 16'h03, 8'h07, 0, 0);
    issue(0, i0(4, 3, 1), 2, 6, 16'hFF, 8'h08, 0, 1);
    issue(0, i0(0, 3, 3), 1, 7, 16'hFE, 8'h09, 1, 1);
    issue(0, i0(2, 3, 1), 1, 8, 16'hFE, 8'h0A, 1, 1);
    issue(0, i0(3, 2, 2), 1, 9, 16'hFE, 8'h0B, 1, 1);
    issue(0, i0(7, 2, 0), 1, 10, 16'hFE, 8'h0C, 0, 1);
    issue(0, i0(0, 3, 0), 1, 11, 16'hFD, 8'h0D, 1, 1);
    issue(0, i0(7, 3, 0), 1, 12, 16'hFD, 8'h0E, 1, 1);
    issue(0, i0(7, 1, 0), 1, 13, 16'h0F, 8'h0F, 1, 1);
    issue(0, i0(7, 0, 2), 1, 14, 16'h0F, 8'h0F, 0, 1);
    issue(0, i0(1, 2, 0), 1, 15, 16'h10, 8'h10, 1, 1);
    issue(0, i0(7, 1, 0), 1, 16, 16'hFD, 8'h11, 1, 1);
    issue(0, i0(5, 2, 0), 1, 17, 16'hFD, 8'h12, 1, 1);
    v0 = 1'b0;
    issue(1, i1(1, 0, 1), 1, 101, 16'h0007, 8'h1, 1, 1);
    issue(1, i1(4, 7, 0), 1, 102, 16'hFFFF, 8'h2, 1, 1);
    issue(1, i1(5, 7, 5), 1, 103, 16'hFFFF, 8'h3, 1, 1);
    issue(1, i1(6, 6, 0), 1, 104, 16'hFFFF, 8'h4, 1, 0);
    issue(1, i1(4, 7, 6), 2, 105, 16'h0005, 8'h5, 1, 1);
    for (int k = 0; k < 4; k++) issue(1, i1(0, 1, 1), 1, 106 + k, 16'h0005, 8'(6 + k), 0, 1);
    issue(1, i1(5, 1, 3), 1, 110, 16'h0005, 8'hA, 0, 1);
    issue(1, i1(3, 2, 2), 1, 111, 16'h0005, 8'hB, 0, 1);
    issue(1, i1(6, 7, 2), 1, 112, 16'h0005, 8'hC, 0, 0);
    issue(1, i1(7, 7, 0), 2, 113, 16'h0003, 8'hD, 0, 1);
    issue(1, i1(7, 5, 0), 1, 114, 16'h000E, 8'hE, 0, 1);
    issue(1, i1(1, 2, 1), 1, 115, 16'h000F, 8'hF, 1, 1);
    issue(1, i1(7, 4, 6), 1, 116, 16'h0004, 8'h4, 0, 1);
    issue(1, i1(7, 7, 0), 1, 117, 16'h0005, 8'h5, 0, 1);
    v1 = 1'b0;
    issue(0, i0(6, 3, 2), 1, 18, 16'hFD, 8'h13, 1, 0);
    v0 = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async pc0", 18, 16'(pc0), 16'h0);
    chk("async carry0", 18, 16'(c0), 16'h0);
    chk("async dOut0", 18, 16'(d0), 16'h3);
    chk("async ready0", 18, 16'(r0), 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset dOut0", 18, 16'(d0), 16'h3);
    chk("post-reset pc0", 18, 16'(pc0), 16'h0);
    chk("post-reset ready0", 18, 16'(r0), 16'h1);
    chk("u0 queue drained", 0, 16'(q0.size()), 16'h0);
    chk("u1 queue drained", 0, 16'(q1.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
